// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and helpers for the round-robin stream mux
package stream_mux_pkg;

  // Channel selection policy, driven straight from mode_i.
  typedef enum logic {
    ModeSel = 1'b0,
    ModeRr  = 1'b1
  } mode_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting its search at ptr
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NumCh = 8,
  localparam int SelW  = sel_width(NumCh)
) (
  input  logic [NumCh-1:0] req_i,
  input  logic [SelW-1:0]  ptr_i,
  input  logic             en_i,
  output logic [NumCh-1:0] gnt_o,
  output logic [SelW-1:0]  gnt_idx_o
);

  int   w_best;
  int   w_best_dist;
  int   w_dist;
  logic w_found;

  // Pick the requester with the smallest upward distance from ptr (with wrap).
  always_comb begin
    w_best      = 0;
    w_best_dist = NumCh;
    w_dist      = 0;
    for (int k = 0; k < NumCh; k++) begin
      if (req_i[k]) begin
        w_dist = (k + NumCh - int'(ptr_i)) % NumCh;
        if (w_dist < w_best_dist) begin
          w_best_dist = w_dist;
          w_best      = k;
        end
      end
    end
  end

  // Expand the winner into a one-hot grant, suppressed when not enabled.
  always_comb begin
    w_found   = en_i && (w_best_dist < NumCh);
    gnt_o     = '0;
    gnt_idx_o = SelW'(w_best);
    for (int k = 0; k < NumCh; k++) begin
      gnt_o[k] = w_found && (k == w_best);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N-channel registered stream mux, select or round-robin
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int Width = 16,
  parameter  int NumCh = 8,
  localparam int SelW  = sel_width(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mode_i,
  input  logic [SelW-1:0]  sel_i,
  input  logic [NumCh-1:0] valid_i,
  input  logic [Width-1:0] data_i [NumCh],
  output logic [NumCh-1:0] ready_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [SelW-1:0]  ch_o,
  input  logic             ready_i
);

  logic             r_valid;
  logic [Width-1:0] r_data;
  logic [SelW-1:0]  r_ch;
  logic [SelW-1:0]  r_ptr;

  mode_e            w_mode;
  logic             w_rr;
  logic             w_accept;
  logic [NumCh-1:0] w_sel_gnt;
  logic [NumCh-1:0] w_arb_gnt;
  logic [SelW-1:0]  w_arb_idx;
  logic [NumCh-1:0] w_gnt;
  logic [SelW-1:0]  w_idx;
  logic             w_xfer;
  logic [Width-1:0] w_data;
  logic [SelW-1:0]  w_ptr_next;

  assign w_mode   = mode_e'(mode_i);
  assign w_rr     = (w_mode == ModeRr);
  assign w_accept = !r_valid || ready_i;

  rr_arbiter #(
    .NumCh (NumCh)
  ) u_arb (
    .req_i     (valid_i),
    .ptr_i     (r_ptr),
    .en_i      (w_accept && rst_ni && w_rr),
    .gnt_o     (w_arb_gnt),
    .gnt_idx_o (w_arb_idx)
  );

  // Select-mode grant; an out-of-range sel_i matches no channel.
  always_comb begin
    w_sel_gnt = '0;
    for (int k = 0; k < NumCh; k++) begin
      w_sel_gnt[k] = valid_i[k] && (sel_i == SelW'(k));
    end
  end

  // Grant mux, ready generation (held low in reset) and winning data select.
  always_comb begin
    w_gnt   = w_rr ? w_arb_gnt : w_sel_gnt;
    w_idx   = w_rr ? w_arb_idx : sel_i;
    ready_o = (rst_ni && w_accept) ? w_gnt : '0;
    w_xfer  = |ready_o;
    w_data  = '0;
    for (int k = 0; k < NumCh; k++) begin
      if (w_gnt[k]) begin
        w_data = data_i[k];
      end
    end
    w_ptr_next = (w_idx == SelW'(NumCh - 1)) ? '0 : w_idx + SelW'(1);
  end

  // Output stage: load on transfer, drop valid on an idle accept, hold on stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
    end else if (w_accept) begin
      r_valid <= w_xfer;
      if (w_xfer) begin
        r_data <= w_data;
        r_ch   <= w_idx;
      end
    end
  end

  // Round-robin pointer moves past the winner only on a round-robin transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (w_xfer && w_rr) begin
      r_ptr <= w_ptr_next;
    end
  end

  assign valid_o = r_valid;
  assign data_o  = r_data;
  assign ch_o    = r_ch;

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel registered stream multiplexer with valid/ready handshakes on every input and on the output. Selects one channel per cycle, either by an explicit select index or by a fair round-robin arbiter, and registers the winner into a single output stage. Sits where the fixed 8:1 registered select mux is used today, wherever producers need backpressure and fair sharing.

## Interface
- Width, 16, data width per channel (≥1)
- NumCh, 8, number of input channels (≥1, not necessarily a power of two)
- SelW (localparam), max(1, $clog2(NumCh)), width of select/channel index

- clk_i  input  1  clock, all logic on rising edge
- rst_ni  input  1  asynchronous active-low reset
- mode_i  input  1  0 = select mode, 1 = round-robin mode
- sel_i  input  SelW  channel index used in select mode
- valid_i  input  NumCh  per-channel valid
- data_i  input  NumCh×Width  per-channel data (unpacked array [NumCh])
- ready_o  output  NumCh  per-channel ready (combinational)
- valid_o  output  1  output valid (registered)
- data_o  output  Width  output data (registered)
- ch_o  output  SelW  index of the channel that produced data_o (registered)
- ready_i  input  1  downstream ready

## Operation
- Output stage can accept when `accept = !valid_o || ready_i`.
- Grant: select mode grants channel sel_i if valid_i[sel_i]; sel_i ≥ NumCh grants nothing. Round-robin mode grants the first valid channel at or after pointer ptr, searching upward with wrap.
- ready_o[k] = accept && grant[k]; at most one bit set. ready_o never depends on valid_o of another channel beyond the grant.
- Input transfer on channel k when valid_i[k] && ready_o[k]: next edge loads data_o ← data_i[k], ch_o ← k, valid_o ← 1.
- accept with no grant: valid_o ← 0; data_o and ch_o hold previous values.
- valid_o && !ready_i: data_o, ch_o, valid_o held stable; all ready_o = 0.
- ptr (SelW bits, internal) advances to (k+1) mod NumCh only on a round-robin input transfer from channel k; wraps NumCh-1 → 0. ptr does not move in select mode or on stall.
- mode_i and sel_i are sampled combinationally each cycle; changes never alter an already-registered output.
- NumCh = 1: both modes degenerate to a pass-through register stage; ch_o always 0.

## Timing
- Reset values: valid_o = 0, data_o = 0, ch_o = 0, ptr = 0. ready_o = 0 during reset (valid_o = 0 so accept = 1, but grants are gated by !rst_ni-released logic: ready_o driven 0 while rst_ni low).
- Latency: input transfer at edge n → valid_o/data_o visible after edge n, 1 cycle.
- Throughput: one transfer per cycle while ready_i held high.
- Output transfer and new input transfer in the same cycle are allowed (accept via ready_i).
- Reset asserted mid-stream: stored beat discarded, outputs return to reset values asynchronously, ptr = 0.
- No combinational path from data_i to data_o; combinational paths valid_i/mode_i/sel_i/ready_i → ready_o are permitted.

## Structure
- Package stream_mux_pkg: mode_e enum (ModeSel = 1'b0, ModeRr = 1'b1); no width-dependent types.
- Sub-module rr_arbiter (parameter NumCh): inputs req, ptr, en; outputs one-hot gnt and gnt_idx. stream_mux_rr instantiates one and muxes it against the select-mode grant.
- Output register, ptr register and grant mux live in stream_mux_rr.

## Test plan
- Reset: rst_ni low with all valid_i = 1 → valid_o = 0, data_o = 0, ch_o = 0, ready_o = 0; release → first grant to channel 0 in round-robin mode.
- Select mode, NumCh = 8, Width = 16: sel_i = 3, data_i[3] = 16'hBEEF, valid_i = 8'hFF, ready_i = 1 → ready_o = 8'h08, next cycle data_o = BEEF, ch_o = 3; sel_i = 3, valid_i[3] = 0 → valid_o drops next cycle.
- Round-robin fairness: valid_i = 8'hFF, ready_i = 1 for 16 cycles → ch_o sequence 0,1,…,7,0,…,7; valid_i = 8'b1000_0001 → alternating 0,7,0,7.
- Backpressure: ready_i = 0 with valid_o = 1 for 5 cycles while data_i changes → data_o, ch_o stable, ready_o = 0, ptr unchanged; ready_i = 1 → next channel granted, no beat lost or duplicated.
- Mode switch and out-of-range: NumCh = 5, mode_i = 0, sel_i = 6 → ready_o = 0, valid_o falls; switch to mode_i = 1 mid-stall → stored beat unchanged, round-robin resumes from ptr.
- Reset mid-stream: assert rst_ni low while valid_o = 1, ready_i = 0 → outputs reset immediately; after release no stale beat appears.
